// File: rtl/xbar_interconnect_if.sv
// Bus bundle for xbar_interconnect: master-side request/response lanes and
// slave-side request/ack lanes, all packed per port.
// Modports: slave = the interconnect's view (takes master requests and slave
// acks, drives grants, responses and slave requests); master = the
// surrounding system's view (drives requests/acks, observes the rest).
interface xbar_interconnect_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]                 i_master_req;
  logic [NUM_MASTERS-1:0]                 i_master_we;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_master_addr;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_master_wdata;
  logic [NUM_MASTERS-1:0]                 o_master_gnt;
  logic [NUM_MASTERS-1:0]                 o_master_rvalid;
  logic [NUM_MASTERS-1:0]                 o_master_err;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] o_master_rdata;

  logic [NUM_SLAVES-1:0]                  o_slave_req;
  logic [NUM_SLAVES-1:0]                  o_slave_we;
  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  o_slave_addr;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  o_slave_wdata;
  logic [NUM_SLAVES-1:0]                  i_slave_ack;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  i_slave_rdata;

  modport slave (
    input  i_master_req, i_master_we, i_master_addr, i_master_wdata,
    output o_master_gnt, o_master_rvalid, o_master_err, o_master_rdata,
    output o_slave_req, o_slave_we, o_slave_addr, o_slave_wdata,
    input  i_slave_ack, i_slave_rdata
  );

  modport master (
    output i_master_req, i_master_we, i_master_addr, i_master_wdata,
    input  o_master_gnt, o_master_rvalid, o_master_err, o_master_rdata,
    input  o_slave_req, o_slave_we, o_slave_addr, o_slave_wdata,
    output i_slave_ack, i_slave_rdata
  );
endinterface

// File: rtl/xbar_interconnect.sv
// Purpose: single-outstanding NxM interconnect, round-robin master arbitration,
//   address-field slave decode, decode errors answered locally.
// Latency: gnt -> rvalid = 2 cycles with same-cycle ack, 1 cycle on decode error.
// Backpressure: requests wait (no gnt) while a transaction is in flight; ISSUE
//   holds the slave request until ack.
// Ports: clk, rst (sync, active-high), bus (xbar_interconnect_if.slave).
// Optional feature: define INTERCONNECT_TIMEOUT_EN to enable the ISSUE watchdog
//   (TIMEOUT_CYCLES); without it ISSUE waits for ack indefinitely.
module xbar_interconnect #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_LSB        = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  xbar_interconnect_if.slave bus
);
  localparam int MW   = $clog2(NUM_MASTERS);
  localparam int SELW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (SEL_LSB + SELW > ADDR_WIDTH || TIMEOUT_CYCLES < 1 || NUM_MASTERS < 2) begin : g_param_check
    $error("xbar_interconnect: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state_q, state_d;
  logic [MW-1:0]           last_grant, idx_q, win;
  logic                    found;
  logic                    we_q, err_q;
  logic [SELW-1:0]         sel_q, win_sel;
  logic                    win_ok;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    timeout;
  logic [NUM_MASTERS-1:0]  gnt, rvalid, err;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rdata;
  logic [NUM_SLAVES-1:0]                  sreq_q, swe_q;
  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  saddr_q;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  swdata_q;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      int c;
      c = (int'(last_grant) + 1 + k) % NUM_MASTERS;
      if (!found && bus.i_master_req[c]) begin
        win   = MW'(c);
        found = 1'b1;
      end
    end
  end

  // Zero-extend before comparing so a power-of-two slave count is not a
  // width-limited constant compare.
  assign win_sel = bus.i_master_addr[win][SEL_LSB +: SELW];
  assign win_ok  = {1'b0, win_sel} < (SELW+1)'(NUM_SLAVES);

`ifdef INTERCONNECT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  // cnt_q counts completed ISSUE cycles; the TIMEOUT_CYCLES-th one expires.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state_q != ISSUE) cnt_q <= '0;
    else                         cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = win_ok ? ISSUE : RESP;
      ISSUE:   if (bus.i_slave_ack[sel_q] || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_grant <= MW'(NUM_MASTERS - 1);
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      sreq_q     <= '0;
      swe_q      <= '0;
      saddr_q    <= '0;
      swdata_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (found) begin
          idx_q      <= win;
          last_grant <= win;
          we_q       <= bus.i_master_we[win];
          sel_q      <= win_sel;
          err_q      <= !win_ok;
          rdata_q    <= '0;
          if (win_ok) begin
            sreq_q[win_sel]   <= 1'b1;
            swe_q[win_sel]    <= bus.i_master_we[win];
            saddr_q[win_sel]  <= bus.i_master_addr[win];
            swdata_q[win_sel] <= bus.i_master_wdata[win];
          end
        end
        ISSUE: if (bus.i_slave_ack[sel_q] || timeout) begin
          // Ack wins over a same-cycle timeout.
          err_q    <= !bus.i_slave_ack[sel_q];
          rdata_q  <= (bus.i_slave_ack[sel_q] && !we_q) ? bus.i_slave_rdata[sel_q] : '0;
          sreq_q   <= '0;
          swe_q    <= '0;
          saddr_q  <= '0;
          swdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Master-facing outputs are combinational off state and are held quiet
  // during reset.
  always_comb begin
    gnt    = '0;
    rvalid = '0;
    err    = '0;
    rdata  = '0;
    if (!rst && state_q == IDLE && found) gnt[win] = 1'b1;
    if (!rst && state_q == RESP) begin
      rvalid[idx_q] = 1'b1;
      err[idx_q]    = err_q;
      rdata[idx_q]  = rdata_q;
    end
  end

  assign bus.o_master_gnt    = gnt;
  assign bus.o_master_rvalid = rvalid;
  assign bus.o_master_err    = err;
  assign bus.o_master_rdata  = rdata;
  assign bus.o_slave_req     = sreq_q;
  assign bus.o_slave_we      = swe_q;
  assign bus.o_slave_addr    = saddr_q;
  assign bus.o_slave_wdata   = swdata_q;
endmodule

// File: tb/tb_xbar_interconnect.sv
// Directed bench for xbar_interconnect (2 masters, 3 slaves, watchdog limit 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
module tb_xbar_interconnect;
  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  xbar_interconnect_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  xbar_interconnect #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SEL_LSB(14), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_gnt;
    logic [DW-1:0] exp_wd;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_master_req   = '0;
    bus.i_master_we    = '0;
    bus.i_master_addr  = '0;
    bus.i_master_wdata = '0;
    bus.i_slave_ack    = '0;
    bus.i_slave_rdata  = '0;
    tick(); tick();

    // Reset: outputs quiet even with a pending request.
    bus.i_master_req = 2'b01;
    #2;
    chk("rst_gnt", 64'(bus.o_master_gnt), 64'h0);
    chk("rst_rvalid", 64'(bus.o_master_rvalid), 64'h0);
    chk("rst_sreq", 64'(bus.o_slave_req), 64'h0);
    chk("rst_rdata", 64'(bus.o_master_rdata), 64'h0);
    tick();

    // Single read: m0 -> slave1, ack one cycle late.
    rst = 1'b0;
    bus.i_master_addr[0] = 32'h0000_4000;
    #2;
    chk("rd_gnt", 64'(bus.o_master_gnt), 64'h1);
    chk("rd_sreq_gntcyc", 64'(bus.o_slave_req), 64'h0);
    tick();
    bus.i_master_req = 2'b00;
    #2;
    chk("rd_sreq_c1", 64'(bus.o_slave_req), 64'h2);
    chk("rd_saddr", 64'(bus.o_slave_addr[1]), 64'h4000);
    chk("rd_swe", 64'(bus.o_slave_we), 64'h0);
    chk("rd_rvalid_c1", 64'(bus.o_master_rvalid), 64'h0);
    tick();
    bus.i_slave_ack[1]   = 1'b1;
    bus.i_slave_rdata[1] = 32'hDEAD_BEEF;
    #2;
    chk("rd_sreq_c2", 64'(bus.o_slave_req), 64'h2);
    tick();
    bus.i_slave_ack   = '0;
    bus.i_slave_rdata = '0;
    #2;
    chk("rd_rvalid", 64'(bus.o_master_rvalid), 64'h1);
    chk("rd_rdata", 64'(bus.o_master_rdata[0]), 64'hDEAD_BEEF);
    chk("rd_err", 64'(bus.o_master_err), 64'h0);
    chk("rd_sreq_resp", 64'(bus.o_slave_req), 64'h0);
    tick();
    #2;
    chk("rd_rvalid_after", 64'(bus.o_master_rvalid), 64'h0);

    // Fresh reset, then both masters write to slave0 with same-cycle ack.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_master_req      = 2'b11;
    bus.i_master_we       = 2'b11;
    bus.i_master_addr[0]  = 32'h0000_0000;
    bus.i_master_addr[1]  = 32'h0000_0010;
    bus.i_master_wdata[0] = 32'h1111_1111;
    bus.i_master_wdata[1] = 32'h2222_2222;
    bus.i_slave_ack[0]    = 1'b1;
    bus.i_slave_rdata[0]  = 32'h5555_AAAA;
    for (int t = 0; t < 4; t++) begin
      exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_wd  = (t % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
      #2;
      chk($sformatf("wr%0d_gnt", t), 64'(bus.o_master_gnt), 64'(exp_gnt));
      tick();
      #2;
      chk($sformatf("wr%0d_sreq", t), 64'(bus.o_slave_req), 64'h1);
      chk($sformatf("wr%0d_swdata", t), 64'(bus.o_slave_wdata[0]), 64'(exp_wd));
      chk($sformatf("wr%0d_gnt_busy", t), 64'(bus.o_master_gnt), 64'h0);
      tick();
      #2;
      chk($sformatf("wr%0d_rvalid", t), 64'(bus.o_master_rvalid), 64'(exp_gnt));
      chk($sformatf("wr%0d_rdata", t), 64'(bus.o_master_rdata), 64'h0);
      tick();
    end
    bus.i_master_req = '0;
    bus.i_master_we  = '0;
    bus.i_slave_ack  = '0;

    // Decode error: m1 to 0xC000 selects nonexistent slave 3.
    bus.i_master_req     = 2'b10;
    bus.i_master_addr[1] = 32'h0000_C000;
    bus.i_slave_rdata    = {3{32'hFFFF_FFFF}};
    #2;
    chk("de_gnt", 64'(bus.o_master_gnt), 64'h2);
    tick();
    bus.i_master_req = '0;
    #2;
    chk("de_rvalid", 64'(bus.o_master_rvalid), 64'h2);
    chk("de_err", 64'(bus.o_master_err), 64'h2);
    chk("de_rdata", 64'(bus.o_master_rdata[1]), 64'h0);
    chk("de_sreq", 64'(bus.o_slave_req), 64'h0);
    tick();
    bus.i_slave_rdata = '0;

    // Reset during ISSUE to slave2 aborts the transaction.
    bus.i_master_req      = 2'b01;
    bus.i_master_we       = 2'b01;
    bus.i_master_addr[0]  = 32'h0000_8000;
    #2;
    chk("ab_gnt", 64'(bus.o_master_gnt), 64'h1);
    tick();
    bus.i_master_req = '0;
    bus.i_master_we  = '0;
    #2;
    chk("ab_sreq_issue", 64'(bus.o_slave_req), 64'h4);
    rst = 1'b1;
    tick();
    #2;
    chk("ab_sreq_dropped", 64'(bus.o_slave_req), 64'h0);
    chk("ab_rvalid_rst", 64'(bus.o_master_rvalid), 64'h0);
    tick();
    rst = 1'b0;
    bus.i_slave_ack[2]   = 1'b1;
    bus.i_master_req     = 2'b11;
    bus.i_master_addr[0] = 32'h0000_4000;
    bus.i_master_addr[1] = 32'h0000_0000;
    #2;
    chk("ab_post_gnt", 64'(bus.o_master_gnt), 64'h1);
    chk("ab_post_rvalid", 64'(bus.o_master_rvalid), 64'h0);
    tick();
    bus.i_master_req = '0;
    #2;
    chk("ab_late_ack_ign", 64'(bus.o_slave_req), 64'h2);
    tick();
    #2;
    chk("ab_late_ack_hold", 64'(bus.o_slave_req), 64'h2);
    bus.i_slave_ack      = 3'b010;
    bus.i_slave_rdata[1] = 32'h1234_5678;
    tick();
    bus.i_slave_ack   = '0;
    bus.i_slave_rdata = '0;
    #2;
    chk("ab_resp_rvalid", 64'(bus.o_master_rvalid), 64'h1);
    chk("ab_resp_rdata", 64'(bus.o_master_rdata[0]), 64'h1234_5678);
    tick();
    #2;
    chk("ab_dropped_req_nognt", 64'(bus.o_master_gnt), 64'h0);
    tick();

    // Slave0 never acks.
    bus.i_master_req     = 2'b01;
    bus.i_master_addr[0] = 32'h0000_0000;
    #2;
    chk("to_gnt", 64'(bus.o_master_gnt), 64'h1);
    tick();
    bus.i_master_req = '0;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk($sformatf("to_sreq_c%0d", k), 64'(bus.o_slave_req), 64'h1);
      tick();
    end
`ifdef INTERCONNECT_TIMEOUT_EN
    #2;
    chk("to_sreq_dropped", 64'(bus.o_slave_req), 64'h0);
    chk("to_rvalid", 64'(bus.o_master_rvalid), 64'h1);
    chk("to_err", 64'(bus.o_master_err), 64'h1);
    chk("to_rdata", 64'(bus.o_master_rdata), 64'h0);
    tick();
`else
    for (int k = 0; k < 100; k++) begin
      #2;
      chk($sformatf("nto_sreq_c%0d", k + 8), 64'(bus.o_slave_req), 64'h1);
      chk($sformatf("nto_rvalid_c%0d", k + 8), 64'(bus.o_master_rvalid), 64'h0);
      tick();
    end
`endif
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
